// File: rtl/vxe_axi_switch_us_p.sv
// vxe_axi_switch_us_p: AXI switch upstream unit.
// Sorts RQA/RQD beats from the VxE master into write-address, write-data and
// read-address FIFOs and presents them to the BIU via pop-driven registers.
module vxe_axi_switch_us_p #(
    parameter int unsigned CID_W           = 6,
    parameter int unsigned ADDR_W          = 40,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2,
    parameter int unsigned STALL_MARGIN    = 2
) (
    input  logic                                        clk,
    input  logic                                        nrst,
    input  logic                                        i_m_rqa_vld,
    input  logic [CID_W+ADDR_W-$clog2(DATA_W/8):0]      i_m_rqa,
    output logic                                        o_m_rqa_rd,
    input  logic                                        i_m_rqd_vld,
    input  logic [DATA_W+(DATA_W/8)-1:0]                i_m_rqd,
    output logic                                        o_m_rqd_rd,
    output logic [CID_W-1:0]                            biu_awcid,
    output logic [ADDR_W-1:0]                           biu_awaddr,
    output logic [DATA_W-1:0]                           biu_awdata,
    output logic [(DATA_W/8)-1:0]                       biu_awstrb,
    output logic                                        biu_awvalid,
    input  logic                                        biu_awpop,
    output logic [CID_W-1:0]                            biu_arcid,
    output logic [ADDR_W-1:0]                           biu_araddr,
    output logic                                        biu_arvalid,
    input  logic                                        biu_arpop,
    output logic [FIFO_DEPTH_LOG2:0]                    o_wa_lvl,
    output logic [FIFO_DEPTH_LOG2:0]                    o_wd_lvl,
    output logic [FIFO_DEPTH_LOG2:0]                    o_ra_lvl,
    output logic                                        o_ovf,
    input  logic                                        i_ovf_clr
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned AL     = $clog2(STRB_W);
    localparam int unsigned AA_W   = ADDR_W - AL;
    localparam int unsigned RQA_W  = CID_W + 1 + AA_W;
    localparam int unsigned AE_W   = CID_W + AA_W;
    localparam int unsigned WD_W   = DATA_W + STRB_W;
    localparam int unsigned DEPTH  = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PW     = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned IW     = FIFO_DEPTH_LOG2;

    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [PW-1:0] THRESH = PW'(DEPTH - STALL_MARGIN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_STLL = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          rd_q, rd_d;
    logic          ovf_q, ovf_d;

    logic [PW-1:0] wa_wp_q, wa_wp_d, wa_rp_q, wa_rp_d;
    logic [PW-1:0] wd_wp_q, wd_wp_d, wd_rp_q, wd_rp_d;
    logic [PW-1:0] ra_wp_q, ra_wp_d, ra_rp_q, ra_rp_d;

    logic [AE_W-1:0] wa_mem_q [DEPTH];
    logic [AE_W-1:0] wa_mem_d [DEPTH];
    logic [WD_W-1:0] wd_mem_q [DEPTH];
    logic [WD_W-1:0] wd_mem_d [DEPTH];
    logic [AE_W-1:0] ra_mem_q [DEPTH];
    logic [AE_W-1:0] ra_mem_d [DEPTH];

    logic [CID_W-1:0]  awcid_q, awcid_d, arcid_q, arcid_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_W-1:0] awdata_q, awdata_d;
    logic [STRB_W-1:0] awstrb_q, awstrb_d;

    logic              wa_empty, wd_empty, ra_empty;
    logic              wa_full, wd_full, ra_full;
    logic              aw_vld, ar_vld, aw_pop, ar_pop;
    logic              cap, rqa_rnw;
    logic [CID_W-1:0]  rqa_cid;
    logic [AA_W-1:0]   rqa_addr;
    logic              wa_req, wd_req, ra_req;
    logic              wa_push, wd_push, ra_push;
    logic              ovf_set, low_space;
    logic [PW-1:0]     wa_lvl_n, wd_lvl_n, ra_lvl_n;
    logic [AE_W-1:0]   wa_head, ra_head;
    logic [WD_W-1:0]   wd_head;

    // FIFO status, request decode and accept/drop decisions
    always_comb begin
        wa_empty = (wa_wp_q == wa_rp_q);
        wd_empty = (wd_wp_q == wd_rp_q);
        ra_empty = (ra_wp_q == ra_rp_q);
        wa_full  = (wa_wp_q[PW-1] != wa_rp_q[PW-1]) && (wa_wp_q[IW-1:0] == wa_rp_q[IW-1:0]);
        wd_full  = (wd_wp_q[PW-1] != wd_rp_q[PW-1]) && (wd_wp_q[IW-1:0] == wd_rp_q[IW-1:0]);
        ra_full  = (ra_wp_q[PW-1] != ra_rp_q[PW-1]) && (ra_wp_q[IW-1:0] == ra_rp_q[IW-1:0]);

        aw_vld = !wa_empty && !wd_empty;
        ar_vld = !ra_empty;
        aw_pop = biu_awpop && aw_vld;
        ar_pop = biu_arpop && ar_vld;

        cap      = (state_q == ST_RECV) || (state_q == ST_STLL);
        rqa_cid  = i_m_rqa[RQA_W-1 -: CID_W];
        rqa_rnw  = i_m_rqa[AA_W];
        rqa_addr = i_m_rqa[AA_W-1:0];

        wa_req = cap && i_m_rqa_vld && !rqa_rnw;
        ra_req = cap && i_m_rqa_vld && rqa_rnw;
        wd_req = cap && i_m_rqd_vld;

        // A full FIFO still accepts when its head leaves in the same cycle
        wa_push = wa_req && (!wa_full || aw_pop);
        wd_push = wd_req && (!wd_full || aw_pop);
        ra_push = ra_req && (!ra_full || ar_pop);
        ovf_set = (wa_req && !wa_push) || (wd_req && !wd_push) || (ra_req && !ra_push);

        wa_head = wa_mem_q[wa_rp_q[IW-1:0]];
        wd_head = wd_mem_q[wd_rp_q[IW-1:0]];
        ra_head = ra_mem_q[ra_rp_q[IW-1:0]];
    end

    // Pointer advance and FIFO storage writes
    always_comb begin
        wa_wp_d  = wa_push ? wa_wp_q + P_ONE : wa_wp_q;
        wd_wp_d  = wd_push ? wd_wp_q + P_ONE : wd_wp_q;
        ra_wp_d  = ra_push ? ra_wp_q + P_ONE : ra_wp_q;
        wa_rp_d  = aw_pop  ? wa_rp_q + P_ONE : wa_rp_q;
        wd_rp_d  = aw_pop  ? wd_rp_q + P_ONE : wd_rp_q;
        ra_rp_d  = ar_pop  ? ra_rp_q + P_ONE : ra_rp_q;

        wa_mem_d = wa_mem_q;
        wd_mem_d = wd_mem_q;
        ra_mem_d = ra_mem_q;
        if (wa_push) wa_mem_d[wa_wp_q[IW-1:0]] = {rqa_cid, rqa_addr};
        if (wd_push) wd_mem_d[wd_wp_q[IW-1:0]] = i_m_rqd;
        if (ra_push) ra_mem_d[ra_wp_q[IW-1:0]] = {rqa_cid, rqa_addr};
    end

    // Rx flow control: stall decision uses post-update occupancy
    always_comb begin
        wa_lvl_n  = wa_wp_d - wa_rp_d;
        wd_lvl_n  = wd_wp_d - wd_rp_d;
        ra_lvl_n  = ra_wp_d - ra_rp_d;
        low_space = (wa_lvl_n > THRESH) || (wd_lvl_n > THRESH) || (ra_lvl_n > THRESH);

        state_d = state_q;
        rd_d    = rd_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RECV;
                rd_d    = 1'b1;
            end
            ST_RECV: begin
                if (low_space) begin
                    state_d = ST_STLL;
                    rd_d    = 1'b0;
                end
            end
            ST_STLL: begin
                if (!low_space) begin
                    state_d = ST_RECV;
                    rd_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rd_d    = 1'b0;
            end
        endcase

        if (ovf_set)        ovf_d = 1'b1;
        else if (i_ovf_clr) ovf_d = 1'b0;
        else                ovf_d = ovf_q;
    end

    // BIU output registers load on an accepted pop, hold otherwise
    always_comb begin
        awcid_d  = awcid_q;
        awaddr_d = awaddr_q;
        awdata_d = awdata_q;
        awstrb_d = awstrb_q;
        arcid_d  = arcid_q;
        araddr_d = araddr_q;
        if (aw_pop) begin
            awcid_d  = wa_head[AE_W-1 -: CID_W];
            awaddr_d = {wa_head[AA_W-1:0], {AL{1'b0}}};
            awdata_d = wd_head[WD_W-1 -: DATA_W];
            awstrb_d = wd_head[STRB_W-1:0];
        end
        if (ar_pop) begin
            arcid_d  = ra_head[AE_W-1 -: CID_W];
            araddr_d = {ra_head[AA_W-1:0], {AL{1'b0}}};
        end
    end

    // State registers; reset discards all FIFO contents at once
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            rd_q     <= 1'b0;
            ovf_q    <= 1'b0;
            wa_wp_q  <= '0;
            wa_rp_q  <= '0;
            wd_wp_q  <= '0;
            wd_rp_q  <= '0;
            ra_wp_q  <= '0;
            ra_rp_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                wa_mem_q[i] <= '0;
                wd_mem_q[i] <= '0;
                ra_mem_q[i] <= '0;
            end
            awcid_q  <= '0;
            awaddr_q <= '0;
            awdata_q <= '0;
            awstrb_q <= '0;
            arcid_q  <= '0;
            araddr_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            ovf_q    <= ovf_d;
            wa_wp_q  <= wa_wp_d;
            wa_rp_q  <= wa_rp_d;
            wd_wp_q  <= wd_wp_d;
            wd_rp_q  <= wd_rp_d;
            ra_wp_q  <= ra_wp_d;
            ra_rp_q  <= ra_rp_d;
            wa_mem_q <= wa_mem_d;
            wd_mem_q <= wd_mem_d;
            ra_mem_q <= ra_mem_d;
            awcid_q  <= awcid_d;
            awaddr_q <= awaddr_d;
            awdata_q <= awdata_d;
            awstrb_q <= awstrb_d;
            arcid_q  <= arcid_d;
            araddr_q <= araddr_d;
        end
    end

    assign o_m_rqa_rd  = rd_q;
    assign o_m_rqd_rd  = rd_q;
    assign biu_awcid   = awcid_q;
    assign biu_awaddr  = awaddr_q;
    assign biu_awdata  = awdata_q;
    assign biu_awstrb  = awstrb_q;
    assign biu_awvalid = aw_vld;
    assign biu_arcid   = arcid_q;
    assign biu_araddr  = araddr_q;
    assign biu_arvalid = ar_vld;
    assign o_wa_lvl    = wa_wp_q - wa_rp_q;
    assign o_wd_lvl    = wd_wp_q - wd_rp_q;
    assign o_ra_lvl    = ra_wp_q - ra_rp_q;
    assign o_ovf       = ovf_q;

endmodule
